// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and a width-independent negate for seq_alu
package alu_pkg;

  typedef enum logic [5:0] {
    CU_LUI    = 6'd0,  CU_AUIPC = 6'd1,  CU_JAL   = 6'd2,  CU_JALR  = 6'd3,
    CU_BEQ    = 6'd4,  CU_BNE   = 6'd5,  CU_BLT   = 6'd6,  CU_BGE   = 6'd7,
    CU_BLTU   = 6'd8,  CU_BGEU  = 6'd9,  CU_LB    = 6'd10, CU_LH    = 6'd11,
    CU_LW     = 6'd12, CU_LBU   = 6'd13, CU_LHU   = 6'd14, CU_SB    = 6'd15,
    CU_SH     = 6'd16, CU_SW    = 6'd17, CU_ADDI  = 6'd18, CU_SLTI  = 6'd19,
    CU_SLTIU  = 6'd20, CU_XORI  = 6'd21, CU_ORI   = 6'd22, CU_ANDI  = 6'd23,
    CU_SLLI   = 6'd24, CU_SRLI  = 6'd25, CU_SRAI  = 6'd26, CU_ADD   = 6'd27,
    CU_SUB    = 6'd28, CU_SLL   = 6'd29, CU_SLT   = 6'd30, CU_SLTU  = 6'd31,
    CU_XOR    = 6'd32, CU_SRL   = 6'd33, CU_SRA   = 6'd34, CU_OR    = 6'd35,
    CU_AND    = 6'd36, CU_FENCE = 6'd37, CU_ERROR = 6'd38,
    CU_MUL    = 6'd39, CU_MULH  = 6'd40, CU_MULHSU = 6'd41, CU_MULHU = 6'd42,
    CU_DIV    = 6'd43, CU_DIVU  = 6'd44, CU_REM   = 6'd45, CU_REMU  = 6'd46
  } cuOPType;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} alu_state_t;

  localparam int NEG_W = 128;

  // Callers size-cast in and out, so one definition serves any width up to NEG_W.
  function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] x);
    return ~x + NEG_W'(1);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// rtl/seq_alu_muldiv_iter.sv - iterative shift-add multiply / restoring divide with sign fix-up
module muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             flush,
  input  logic             load,
  input  cuOPType          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic             special,
  output logic [WIDTH-1:0] special_result,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             is_div, sel_hi, a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [2*WIDTH-1:0] acc, mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   opnd, div_sel, div_fix;
  logic [CW-1:0]      cnt;
  logic               r_div, r_hi, r_neg;
  logic [WIDTH:0]     sum, r_sh, diff;

  always_comb begin
    is_div = op inside {CU_DIV, CU_DIVU, CU_REM, CU_REMU};
    sel_hi = op inside {CU_MULH, CU_MULHSU, CU_MULHU, CU_REM, CU_REMU};
    a_sgn  = op inside {CU_MUL, CU_MULH, CU_MULHSU, CU_DIV, CU_REM};
    b_sgn  = op inside {CU_MUL, CU_MULH, CU_DIV, CU_REM};
    a_neg  = a_sgn & a[WIDTH-1];
    b_neg  = b_sgn & b[WIDTH-1];
    mag_a  = a_neg ? WIDTH'(twos_neg(NEG_W'(a))) : a;
    mag_b  = b_neg ? WIDTH'(twos_neg(NEG_W'(b))) : b;
    special = is_div && ((b == '0) ||
              (a_sgn && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1));
    if (b == '0) special_result = sel_hi ? a : '1;
    else         special_result = sel_hi ? '0 : a;
  end

  // One iteration step: multiplier/quotient bits live in the low half of acc.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    r_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = r_sh - {1'b0, opnd};
    div_next = diff[WIDTH] ? {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      r_div <= 1'b0;
      r_hi  <= 1'b0;
      r_neg <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
      opnd  <= is_div ? mag_b : mag_a;
      cnt   <= CW'(WIDTH);
      r_div <= is_div;
      r_hi  <= sel_hi;
      r_neg <= (is_div && sel_hi) ? a_neg : (a_neg ^ b_neg);
    end else if (cnt != '0) begin
      acc <= r_div ? div_next : mul_next;
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));

  always_comb begin
    prod_fix = r_neg ? (2*WIDTH)'(twos_neg(NEG_W'(acc))) : acc;
    div_sel  = r_hi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    div_fix  = r_neg ? WIDTH'(twos_neg(NEG_W'(div_sel))) : div_sel;
    if (r_div)     result = div_fix;
    else if (r_hi) result = prod_fix[2*WIDTH-1:WIDTH];
    else           result = prod_fix[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle integer ops plus iterative RV32M behind start/done
module seq_alu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             flush,
  input  cuOPType          aluOP,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             negative,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);

  alu_state_t       state, next_state;
  logic             accept, load_md, is_mop, is_div_op;
  logic             md_last, md_special;
  logic [WIDTH-1:0] simple_res, pending, md_result, md_special_result;
  logic [SW-1:0]    shamt;

  assign is_mop    = aluOP inside {CU_MUL, CU_MULH, CU_MULHSU, CU_MULHU,
                                   CU_DIV, CU_DIVU, CU_REM, CU_REMU};
  assign is_div_op = aluOP inside {CU_DIV, CU_DIVU, CU_REM, CU_REMU};
  assign shamt     = inputB[SW-1:0];

  always_comb begin
    simple_res = '0;
    case (aluOP)
      CU_ADD:  simple_res = inputA + inputB;
      CU_SUB:  simple_res = inputA - inputB;
      CU_AND:  simple_res = inputA & inputB;
      CU_OR:   simple_res = inputA | inputB;
      CU_XOR:  simple_res = inputA ^ inputB;
      CU_SLL:  simple_res = inputA << shamt;
      CU_SRL:  simple_res = inputA >> shamt;
      CU_SRA:  simple_res = $signed(inputA) >>> shamt;
      CU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, $signed(inputA) < $signed(inputB)};
      CU_SLTU: simple_res = {{(WIDTH-1){1'b0}}, inputA < inputB};
      default: simple_res = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk            (clk),
    .nRst           (nRst),
    .flush          (flush),
    .load           (load_md),
    .op             (aluOP),
    .a              (inputA),
    .b              (inputB),
    .last           (md_last),
    .special        (md_special),
    .special_result (md_special_result),
    .result         (md_result)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_md    = 1'b0;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          accept = 1'b1;
          if (is_mop && !md_special) begin
            load_md    = 1'b1;
            next_state = is_div_op ? DIV : MUL;
          end else begin
            next_state = DONE;
          end
        end
        MUL, DIV: if (md_last) next_state = FIX;
        FIX:      next_state = DONE;
        DONE:     next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // pending stages the answer so ALUResult and done update together on leaving DONE.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pending   <= '0;
      ALUResult <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) pending <= is_mop ? md_special_result : simple_res;
      if (!flush && state == FIX) pending <= md_result;
      if (!flush && state == DONE) begin
        ALUResult <= pending;
        done      <= 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign negative = ALUResult[WIDTH-1];
  assign zero     = (ALUResult == '0);

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed self-checking bench for seq_alu
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk, nRst, start, flush;
  cuOPType     aluOP;
  logic [31:0] inputA, inputB, ALUResult;
  logic        negative, zero, busy, done;
  int          checks = 0;
  int          errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .nRst(nRst), .start(start), .flush(flush), .aluOP(aluOP),
    .inputA(inputA), .inputB(inputB), .ALUResult(ALUResult),
    .negative(negative), .zero(zero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(cuOPType op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = int'(b[4:0]);
    case (op)
      CU_ADD:    return a + b;
      CU_SUB:    return a - b;
      CU_AND:    return a & b;
      CU_OR:     return a | b;
      CU_XOR:    return a ^ b;
      CU_SLL:    return a << sh;
      CU_SRL:    return a >> sh;
      CU_SRA:    return $signed(a) >>> sh;
      CU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      CU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      CU_MUL:    begin p = sa * sb; return p[31:0];  end
      CU_MULH:   begin p = sa * sb; return p[63:32]; end
      CU_MULHSU: begin p = sa * ub; return p[63:32]; end
      CU_MULHU:  begin p = ua * ub; return p[63:32]; end
      CU_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return 32'(sa / sb);
      CU_REM:  if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
               else return 32'(sa % sb);
      CU_DIVU: if (b == 0) return 32'hFFFF_FFFF; else return 32'(ua / ub);
      CU_REMU: if (b == 0) return a; else return 32'(ua % ub);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(cuOPType op, logic [31:0] a, logic [31:0] b);
    logic m, d, ovf;
    m   = (int'(op) >= 39 && int'(op) <= 46);
    d   = (op == CU_DIV || op == CU_DIVU || op == CU_REM || op == CU_REMU);
    ovf = (op == CU_DIV || op == CU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (m && !(d && (b == 0 || ovf))) return 34;
    return 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, follow it to done and compare against the reference.
  task automatic run_op(input cuOPType op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          cyc, busy_bad;
    logic        seen;
    exp = ref_result(op, a, b);
    @(negedge clk);
    start = 1'b1; aluOP = op; inputA = a; inputB = b;
    @(posedge clk); #1;
    start = 1'b0; inputA = $urandom; inputB = $urandom; aluOP = cuOPType'(6'($urandom_range(0, 63)));
    cyc = 0; busy_bad = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (!busy) busy_bad++;
      @(posedge clk); #1;
      cyc++;
      seen = done;
    end
    check({tag, " latency"}, 64'(cyc), 64'(ref_latency(op, a, b)));
    check({tag, " busy held"}, 64'(busy_bad), 64'd0);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(ALUResult), 64'(exp));
    check({tag, " negative"}, 64'(negative), 64'(exp[31]));
    check({tag, " zero"}, 64'(zero), 64'(exp == 32'd0));
  endtask

  task automatic expect_quiet(input int n, input logic [31:0] keep, input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) hits++;
    end
    check({tag, " no done"}, 64'(hits), 64'd0);
    check({tag, " result kept"}, 64'(ALUResult), 64'(keep));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cuOPType op;
    logic [31:0] held;
    int cyc;
    nRst = 1'b0; start = 1'b0; flush = 1'b0; aluOP = CU_ADD; inputA = '0; inputB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", 64'(ALUResult), 64'd0);
    check("reset negative", 64'(negative), 64'd0);
    check("reset zero", 64'(zero), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    @(negedge clk); nRst = 1'b1;

    run_op(CU_ADD,    32'h7FFF_FFFF, 32'd1,         "add ovf");
    run_op(CU_SLT,    32'd5,         32'd3,         "slt");
    run_op(CU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    run_op(CU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(CU_DIV,    32'hFFFF_FFF9, 32'd2,         "div -7/2");
    run_op(CU_REM,    32'hFFFF_FFF9, 32'd2,         "rem -7/2");
    run_op(CU_DIVU,   32'd7,         32'd0,         "divu by0");
    run_op(CU_REMU,   32'd7,         32'd0,         "remu by0");
    run_op(CU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    run_op(CU_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
    run_op(CU_MULHSU, 32'hFFFF_FFFE, 32'h8000_0000, "mulhsu");

    // start while busy is dropped
    held = ref_result(CU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk); start = 1'b1; aluOP = CU_MULHU; inputA = 32'h1234_5678; inputB = 32'h9ABC_DEF0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); start = 1'b1; aluOP = CU_ADD; inputA = 32'd1; inputB = 32'd1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("busy start latency", 64'(cyc), 64'd34);
    check("busy start result", 64'(ALUResult), 64'(held));
    expect_quiet(5, held, "busy start");

    // flush at iteration 5 of DIVU
    run_op(CU_ADD, 32'h1000, 32'h234, "pre flush");
    held = 32'h1234;
    @(negedge clk); start = 1'b1; aluOP = CU_DIVU; inputA = 32'd1000; inputB = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    expect_quiet(40, held, "flush");

    // start and flush together in IDLE
    @(negedge clk); start = 1'b1; flush = 1'b1; aluOP = CU_ADD; inputA = 32'd5; inputB = 32'd6;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush+start busy", 64'(busy), 64'd0);
    expect_quiet(4, held, "flush+start");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 6) op = cuOPType'(6'($urandom_range(39, 46)));
      else                          op = cuOPType'(6'($urandom_range(0, 63)));
      run_op(op, pick_operand(), pick_operand(), $sformatf("rnd%0d op%0d", i, int'(op)));
    end

    // reset during iteration 10 of MUL
    run_op(CU_OR, 32'hF000_0000, 32'h5, "pre reset");
    @(negedge clk); start = 1'b1; aluOP = CU_MUL; inputA = 32'd12345; inputB = 32'd678;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2 nRst = 1'b0;
    #1;
    check("midreset result", 64'(ALUResult), 64'd0);
    check("midreset negative", 64'(negative), 64'd0);
    check("midreset zero", 64'(zero), 64'd1);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    @(negedge clk); nRst = 1'b1;
    expect_quiet(40, 32'd0, "midreset");
    run_op(CU_MUL, 32'hFFFF_FFFD, 32'd7, "post reset mul");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the core's combinational ALU. It adds the RV32M multiply/divide group, executed iteratively, to the existing integer op set, behind a start/done handshake, with a registered result and flags. It sits in the execute stage; the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand/result width (≥ 8, even).
- `clk`  in  1  rising-edge clock.
- `nRst`  in  1  asynchronous active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `flush`  in  1  synchronous abort of the in-flight op.
- `aluOP`  in  6  `cuOPType` opcode, sampled on accept.
- `inputA`, `inputB`  in  WIDTH  operands, sampled on accept.
- `ALUResult`  out  WIDTH  registered result, held until the next accept.
- `negative`  out  1  `ALUResult[WIDTH-1]`.
- `zero`  out  1  `ALUResult`==0, valid for every op, including SLT/SLTU.
- `busy`  out  1  op in flight; new `start` is ignored.
- `done`  out  1  one-cycle pulse, same cycle the new result appears.

## Operation
- Single-cycle ops (result registered on accept):
  - CU_ADD, SUB, AND, OR, XOR.
  - CU_SLL, SRL, SRA, with shift amount = `inputB[$clog2(WIDTH)-1:0]`.
  - CU_SLT (signed), CU_SLTU (unsigned).
  - Any other non-M opcode: result 0.
- Iterative ops: CU_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- State machine, in `alu_pkg`: IDLE, MUL, DIV, FIX, DONE.
  - IDLE + `start`, single-cycle op: compute, go to DONE.
  - IDLE + `start`, M-op: latch the magnitudes of the operands and record the result sign. Then go to MUL or DIV; a DIV special case goes straight to DONE.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, into a 2·WIDTH accumulator, then go to FIX.
  - DIV: restoring, one quotient bit per cycle, WIDTH cycles, then go to FIX.
  - FIX: apply the sign (two's-complement negate), select the low or high half (or quotient or remainder), then go to DONE.
  - DONE: `done`=1, return to IDLE. `busy`=1 in all states except IDLE.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - REM takes the sign of the dividend.
- DIV special cases, resolved at accept with no iteration:
  - B==0: quotient = all ones, remainder = A.
  - Signed A = most-negative, B = −1: quotient = A, remainder 0.
- `flush` has priority over all other state transitions. Next state is IDLE, no `done` pulse, and `ALUResult` keeps its previous value.
- A `start` that arrives while `busy`=1 is dropped silently.
- `start` and `flush` in the same IDLE cycle: `flush` wins, nothing is accepted.

## Timing
- Reset (async, `nRst`=0):
  - State = IDLE.
  - `ALUResult` = 0, `negative` = 0, `zero` = 1, `busy` = 0, `done` = 0.
  - Internal accumulators cleared.
- Accept happens at edge N, when IDLE and `start`=1.
- Single-cycle op or DIV special case: result and `done` visible after edge N+1. Latency 1; back-to-back throughput is one op per 2 cycles.
- Mul/div: WIDTH iteration cycles + FIX + DONE. `done` is visible after edge N+WIDTH+2 (34 cycles for WIDTH=32).
- `busy` rises after edge N and falls in the same cycle `done` is asserted. `start` may be re-asserted in the `done` cycle, and is accepted at the next edge.
- Operands may change after the accept edge; they are captured internally.
- Reset asserted mid-operation: immediate return to the reset values, no `done` pulse.

## Structure
- `alu_pkg` holds:
  - `cuOPType`. Existing encodings are unchanged (CU_LUI=0 … CU_ERROR=38). CU_MUL … CU_REMU are appended as 39–46.
  - The state enum.
  - A `WIDTH`-independent helper function for two's-complement negate.
- The natural sub-module is `muldiv_iter`: the MUL/DIV datapath (accumulator, iteration counter, sign fix-up). `seq_alu` owns the FSM, the single-cycle ops and the output registers.

## Test plan
- Reset mid-MUL: set `nRst`=0 at iteration 10 → outputs go to their reset values immediately, and no `done` appears afterwards.
- ADD 0x7FFFFFFF + 1 → `ALUResult`=0x80000000, `negative`=1, `zero`=0, `done` one cycle after accept. SLT 5 < 3 → 0, `zero`=1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0, and MULHU of the same operands → 0xFFFFFFFE. Both with `done` exactly 34 cycles after accept, `busy` high throughout.
- DIV −7 / 2 → −3 and REM → −1. DIVU 7 / 0 → 0xFFFFFFFF and REMU → 7, with 1-cycle latency.
- DIV 0x80000000 / −1 → 0x80000000, REM → 0, with 1-cycle latency.
- `flush` at iteration 5 of DIVU → IDLE next cycle, no `done`, previous `ALUResult` retained. A `start` while busy has no effect.
